// File: rtl/slot_model_pkg.sv
// Shared types and helpers for the I2S slot model: merge arbitration mode and lane mask utilities.
package slot_model_pkg;

    typedef enum logic {
        MERGE_STRICT = 1'b0,
        MERGE_SKIP   = 1'b1
    } merge_mode_t;

    localparam int MAX_LANES = 16;

    // Index of the lowest set bit; MAX_LANES when the mask is empty.
    function automatic logic [4:0] lowest_set(input logic [MAX_LANES-1:0] mask);
        lowest_set = 5'(MAX_LANES);
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = 5'(i);
        end
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty flags and a synchronous flush.
module lane_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             sample_clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             write,
    input  logic [WIDTH-1:0] wdata,
    input  logic             read,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_write;
    logic             do_read;

    assign do_write = write && !full;
    assign do_read  = read && !empty;
    assign rdata    = mem[rd_ptr];

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        count_next = count;
        if (do_write && !do_read) begin
            count_next = count + 1'b1;
        end else if (do_read && !do_write) begin
            count_next = count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sample_clk) begin
        if (!reset_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
        end
    end

    // NOTE: storage is not reset; the pointers and flags alone define what is valid.
    always_ff @(posedge sample_clk) begin
        if (do_write) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/i2s_lane_merger.sv
// Merges per-lane I2S sample streams into one tagged stream with strict or work-conserving
// round-robin arbitration, per-lane buffering and saturating drop counters.
module i2s_lane_merger
    import slot_model_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int SAMPLE_BITS = 48,
    parameter int DEPTH       = 4,
    parameter int CNT_BITS    = 16
) (
    input  logic                             sample_clk,
    input  logic                             reset_n,
    input  logic                             sync_clear,
    input  logic                             mode,
    input  logic [NUM_LANES-1:0]             lane_enable,
    input  logic [NUM_LANES-1:0]             in_valid,
    input  logic [NUM_LANES*SAMPLE_BITS-1:0] in_data,
    output logic [NUM_LANES-1:0]             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SAMPLE_BITS-1:0]           out_data,
    output logic [$clog2(NUM_LANES):0]       out_lane,
    output logic                             out_frame_start,
    output logic [NUM_LANES*CNT_BITS-1:0]    drop_count
);

    localparam int LW = $clog2(NUM_LANES) + 1;
    typedef logic [LW-1:0] lane_idx_t;

    function automatic lane_idx_t wrap_add(input lane_idx_t base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_LANES) sum = sum - NUM_LANES;
        return lane_idx_t'(sum);
    endfunction

    merge_mode_t cur_mode;
    assign cur_mode = merge_mode_t'(mode);

    logic [NUM_LANES-1:0][SAMPLE_BITS-1:0] lane_data;
    logic [SAMPLE_BITS-1:0]                fifo_rdata [NUM_LANES];
    logic [NUM_LANES-1:0]                  fifo_full;
    logic [NUM_LANES-1:0]                  fifo_empty;
    logic [NUM_LANES-1:0]                  fifo_write;
    logic [NUM_LANES-1:0]                  fifo_read;
    logic [NUM_LANES-1:0]                  lane_avail;
    logic [NUM_LANES-1:0]                  lane_drop;
    logic [NUM_LANES-1:0][CNT_BITS-1:0]    drop_cnt;

    lane_idx_t rr_index;
    lane_idx_t rr_d;
    lane_idx_t next_enabled;
    lane_idx_t skip_lane;
    lane_idx_t grant_lane;
    logic      skip_found;
    logic      grant_valid;
    logic      take;

    logic [MAX_LANES-1:0] enable_wide;
    logic [4:0]           lowest_lane;

    assign lane_data  = in_data;
    assign drop_count = drop_cnt;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign fifo_write[i] = in_valid[i] && lane_enable[i] && !fifo_full[i];
        assign lane_drop[i]  = in_valid[i] && lane_enable[i] && fifo_full[i];
        assign in_ready[i]   = !fifo_full[i] || !lane_enable[i];
        assign lane_avail[i] = lane_enable[i] && !fifo_empty[i];
        assign fifo_read[i]  = take && (int'(grant_lane) == i);

        // A disabled lane is held in flush so it restarts empty when re-enabled.
        lane_fifo #(
            .WIDTH (SAMPLE_BITS),
            .DEPTH (DEPTH)
        ) u_fifo (
            .sample_clk (sample_clk),
            .reset_n    (reset_n),
            .clear      (sync_clear || !lane_enable[i]),
            .write      (fifo_write[i]),
            .wdata      (lane_data[i]),
            .read       (fifo_read[i]),
            .rdata      (fifo_rdata[i]),
            .full       (fifo_full[i]),
            .empty      (fifo_empty[i])
        );
    end

    always_comb begin
        enable_wide                = '0;
        enable_wide[NUM_LANES-1:0] = lane_enable;
        lowest_lane                = lowest_set(enable_wide);
    end

    // Descending scans let the nearest candidate after rr_index win without a found flag.
    always_comb begin
        next_enabled = rr_index;
        for (int k = NUM_LANES; k >= 1; k--) begin
            if (lane_enable[wrap_add(rr_index, k)]) next_enabled = wrap_add(rr_index, k);
        end

        skip_found = 1'b0;
        skip_lane  = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (lane_avail[wrap_add(rr_index, k)]) begin
                skip_found = 1'b1;
                skip_lane  = wrap_add(rr_index, k);
            end
        end

        grant_valid = 1'b0;
        grant_lane  = '0;
        case (cur_mode)
            MERGE_STRICT: begin
                if (lane_avail[rr_index]) begin
                    grant_valid = 1'b1;
                    grant_lane  = rr_index;
                end
            end
            MERGE_SKIP: begin
                grant_valid = skip_found;
                grant_lane  = skip_lane;
            end
        endcase

        take = grant_valid && (!out_valid || out_ready);

        rr_d = rr_index;
        if (cur_mode == MERGE_STRICT) begin
            if (!lane_enable[rr_index] || take) rr_d = next_enabled;
        end else if (take) begin
            rr_d = wrap_add(grant_lane, 1);
        end
    end

    always_ff @(posedge sample_clk) begin
        if (!reset_n || sync_clear) begin
            rr_index <= '0;
        end else begin
            rr_index <= rr_d;
        end
    end

    always_ff @(posedge sample_clk) begin
        if (!reset_n || sync_clear) begin
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_lane        <= '0;
            out_frame_start <= 1'b0;
        end else if (take) begin
            out_valid       <= 1'b1;
            out_data        <= fifo_rdata[grant_lane];
            out_lane        <= grant_lane;
            out_frame_start <= (int'(grant_lane) == int'(lowest_lane));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Drops arriving during a flush are not counted; the counters survive sync_clear.
    always_ff @(posedge sample_clk) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (!sync_clear) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_drop[i] && (drop_cnt[i] != '1)) drop_cnt[i] <= drop_cnt[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_lane_merger.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_i2s_lane_merger;

    localparam int NL = 4;
    localparam int SB = 48;
    localparam int DP = 4;
    localparam int CB = 4;
    localparam int SAT = (1 << CB) - 1;

    logic                 sample_clk;
    logic                 reset_n;
    logic                 sync_clear;
    logic                 mode;
    logic [NL-1:0]        lane_enable;
    logic [NL-1:0]        in_valid;
    logic [NL*SB-1:0]     in_data;
    logic [NL-1:0]        in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [SB-1:0]        out_data;
    logic [$clog2(NL):0]  out_lane;
    logic                 out_frame_start;
    logic [NL*CB-1:0]     drop_count;

    i2s_lane_merger #(
        .NUM_LANES   (NL),
        .SAMPLE_BITS (SB),
        .DEPTH       (DP),
        .CNT_BITS    (CB)
    ) dut (
        .sample_clk      (sample_clk),
        .reset_n         (reset_n),
        .sync_clear      (sync_clear),
        .mode            (mode),
        .lane_enable     (lane_enable),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_lane        (out_lane),
        .out_frame_start (out_frame_start),
        .drop_count      (drop_count)
    );

    initial begin
        sample_clk = 1'b0;
        forever #5 sample_clk = ~sample_clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: lane buffers as queues, output register as plain variables.
    typedef logic [SB-1:0] sample_q_t [$];
    sample_q_t     mq [NL];
    bit            m_ov;
    logic [SB-1:0] m_od;
    int            m_ol;
    bit            m_fs;
    int            m_rr;
    int            m_drop [NL];
    bit            cmp_on = 1'b0;

    function automatic int lowest_of(input logic [NL-1:0] m);
        for (int i = 0; i < NL; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int next_enabled_after(input int r, input logic [NL-1:0] m);
        for (int k = 1; k <= NL; k++) if (m[(r + k) % NL]) return (r + k) % NL;
        return r;
    endfunction

    always @(posedge sample_clk) begin
        if (!reset_n || sync_clear) begin
            for (int i = 0; i < NL; i++) begin
                mq[i].delete();
                if (!reset_n) m_drop[i] = 0;
            end
            m_ov = 1'b0; m_od = '0; m_ol = 0; m_fs = 1'b0; m_rr = 0;
        end else begin
            int  g;
            int  sz [NL];
            bit  load_ok;
            g = -1;
            for (int i = 0; i < NL; i++) sz[i] = mq[i].size();
            load_ok = !m_ov || out_ready;
            if (mode == 1'b0) begin
                if (lane_enable != '0) begin
                    if (!lane_enable[m_rr]) begin
                        m_rr = next_enabled_after(m_rr, lane_enable);
                    end else if (sz[m_rr] > 0 && load_ok) begin
                        g = m_rr;
                        m_rr = next_enabled_after(m_rr, lane_enable);
                    end
                end
            end else begin
                for (int k = 0; k < NL; k++) begin
                    int c;
                    c = (m_rr + k) % NL;
                    if (g < 0 && lane_enable[c] && sz[c] > 0) g = c;
                end
                if (g >= 0 && load_ok) m_rr = (g + 1) % NL;
                else g = -1;
            end
            if (g >= 0) begin
                m_od = mq[g].pop_front();
                m_ov = 1'b1;
                m_ol = g;
                m_fs = (g == lowest_of(lane_enable));
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            for (int i = 0; i < NL; i++) begin
                if (!lane_enable[i]) begin
                    mq[i].delete();
                end else if (in_valid[i]) begin
                    if (sz[i] < DP) mq[i].push_back(in_data[i*SB +: SB]);
                    else if (m_drop[i] < SAT) m_drop[i]++;
                end
            end
        end
    end

    always @(negedge sample_clk) begin
        if (cmp_on) begin
            check("out_valid", 64'(out_valid), 64'(m_ov));
            if (m_ov) begin
                check("out_data", 64'(out_data), 64'(m_od));
                check("out_lane", 64'(out_lane), 64'(m_ol));
                check("out_frame_start", 64'(out_frame_start), 64'(m_fs));
            end
            for (int i = 0; i < NL; i++) begin
                check("in_ready", 64'(in_ready[i]), 64'((mq[i].size() < DP) || !lane_enable[i]));
                check("drop_count", 64'(drop_count[i*CB +: CB]), 64'(m_drop[i]));
            end
        end
    end

    // Accepted-output recorder for the backpressure test.
    bit            capture = 1'b0;
    logic [SB-1:0] acc_q [$];
    always @(negedge sample_clk) begin
        if (capture && out_valid && out_ready) acc_q.push_back(out_data);
    end

    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        sync_clear = 1'b0;
        in_valid   = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_lane(input int i, input logic [SB-1:0] d);
        in_data[i*SB +: SB] = d;
    endtask

    initial begin
        int accepts;
        int cycles;
        logic [63:0] r;
        int exp_lane [4];

        reset_n = 1'b0; sync_clear = 1'b0; mode = 1'b0;
        lane_enable = '1; in_valid = '0; in_data = '0; out_ready = 1'b1;
        do_reset();
        cmp_on = 1'b1;

        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'hF);
        check("reset drop_count", 64'(drop_count), 64'd0);

        // 1: simultaneous push on all lanes, strict order 0..3
        for (int i = 0; i < NL; i++) set_lane(i, SB'(8'hA0 + i));
        in_valid = '1;
        tick();
        in_valid = '0;
        for (int k = 0; k < NL; k++) begin
            tick();
            check("t1 valid", 64'(out_valid), 64'd1);
            check("t1 lane", 64'(out_lane), 64'(k));
            check("t1 data", 64'(out_data), 64'(8'hA0 + k));
            check("t1 frame_start", 64'(out_frame_start), 64'(k == 0));
        end

        // 2: strict starvation, then skip mode drains lane 2
        for (int k = 0; k < 3; k++) begin
            in_valid = 4'b0100;
            set_lane(2, SB'(8'hC0 + k));
            tick();
        end
        in_valid = '0;
        accepts = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (out_valid) accepts++;
        end
        check("t2 starved", 64'(accepts), 64'd0);
        mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2 skip lane", 64'(out_lane), 64'd2);
            check("t2 skip data", 64'(out_data), 64'(8'hC0 + k));
        end

        // 3: overflow of lane 1 with consumer stalled
        do_reset();
        mode = 1'b1; out_ready = 1'b0; lane_enable = '1;
        accepts = 0;
        for (int k = 0; k < 7; k++) begin
            in_valid = 4'b0010;
            set_lane(1, SB'(16'h1000 + k));
            if (in_ready[1]) accepts++;
            tick();
        end
        in_valid = '0;
        check("t3 accepts", 64'(accepts), 64'd5);
        check("t3 in_ready1", 64'(in_ready[1]), 64'd0);
        check("t3 drops", 64'(drop_count[1*CB +: CB]), 64'd2);

        // 4: saturation of the 4-bit drop counter
        in_valid = 4'b0010;
        for (int k = 0; k < 20; k++) tick();
        in_valid = '0;
        check("t4 saturated", 64'(drop_count[1*CB +: CB]), 64'd15);

        // 6a: sync_clear with samples buffered keeps drop counts
        sync_clear = 1'b1;
        tick();
        sync_clear = 1'b0;
        check("t6 clr out_valid", 64'(out_valid), 64'd0);
        check("t6 clr in_ready", 64'(in_ready), 64'hF);
        check("t6 clr drops kept", 64'(drop_count[1*CB +: CB]), 64'd15);
        out_ready = 1'b1;
        accepts = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (out_valid) accepts++;
        end
        check("t6 clr fifo empty", 64'(accepts), 64'd0);

        // 6b: reset with samples buffered clears drop counts
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 4'b0001;
            set_lane(0, SB'(k));
            tick();
        end
        in_valid = '0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6 rst out_valid", 64'(out_valid), 64'd0);
        check("t6 rst drops", 64'(drop_count), 64'd0);
        out_ready = 1'b1;
        accepts = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (out_valid) accepts++;
        end
        check("t6 rst fifo empty", 64'(accepts), 64'd0);

        // 6c: enable mask 1010 in skip mode
        lane_enable = 4'b1010; mode = 1'b1;
        for (int i = 0; i < NL; i++) set_lane(i, SB'(8'hD0 + i));
        in_valid = '1;
        tick();
        for (int i = 0; i < NL; i++) set_lane(i, SB'(8'hE0 + i));
        tick();
        in_valid = '0;
        exp_lane = '{1, 3, 1, 3};
        for (int k = 0; k < 4; k++) begin
            check("t6 mask lane", 64'(out_lane), 64'(exp_lane[k]));
            check("t6 mask data", 64'(out_data), 64'((k < 2 ? 8'hD0 : 8'hE0) + exp_lane[k]));
            check("t6 mask frame_start", 64'(out_frame_start), 64'(exp_lane[k] == 1));
            tick();
        end

        // 5: backpressure with toggling out_ready on a single strict lane
        lane_enable = 4'b0001; mode = 1'b0;
        acc_q.delete();
        capture = 1'b1;
        accepts = 0;
        cycles = 0;
        while (accepts < 8 && cycles < 100) begin
            out_ready = ~out_ready;
            set_lane(0, SB'(16'h0100 + accepts));
            in_valid = 4'b0001;
            if (in_ready[0]) accepts++;
            tick();
            cycles++;
        end
        in_valid = '0;
        cycles = 0;
        while (acc_q.size() < 8 && cycles < 60) begin
            out_ready = ~out_ready;
            tick();
            cycles++;
        end
        capture = 1'b0;
        check("t5 count", 64'(acc_q.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < acc_q.size()) check("t5 order", 64'(acc_q[k]), 64'(16'h0100 + k));
        end

        // Randomized phase against the model
        out_ready = 1'b1;
        lane_enable = '1;
        for (int c = 0; c < 3000; c++) begin
            reset_n    = ($urandom_range(0, 499) != 0);
            sync_clear = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            if ($urandom_range(0, 39) == 0)
                lane_enable = ($urandom_range(0, 2) == 0) ? 4'hF : NL'($urandom);
            in_valid  = NL'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NL; i++) begin
                r = {$urandom, $urandom};
                set_lane(i, r[SB-1:0]);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
